// File: rtl/dcache_responder_pkg.sv
// rtl/dcache_responder_pkg.sv - shared state encodings and geometry constants for the data cache
package dcache_responder_pkg;

    localparam int DC_INDEX_BITS = 4;
    localparam int DC_ADDR_W     = 32;
    localparam int DC_LINES      = 1 << DC_INDEX_BITS;
    localparam int DC_TAG_W      = DC_ADDR_W - DC_INDEX_BITS - 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Tag width left over once the word offset and the line index are removed.
    function automatic int tag_width(input int addr_w, input int index_bits);
        return addr_w - index_bits - 2;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/tag/data line storage with combinational lookup and one write port
module dcache_array
    import dcache_responder_pkg::*;
#(
    parameter int INDEX_BITS = DC_INDEX_BITS,
    parameter int TAG_W      = DC_TAG_W
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_hit,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Any write makes its line valid; a write-hit rewrites the same tag so this is harmless.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    // Only the valid bits are cleared on reset; tag and data are don't-care until valid.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_data = data_q[rd_index];

endmodule

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through no-write-allocate data cache for the MEM stage
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int INDEX_BITS = DC_INDEX_BITS,
    parameter int ADDR_W     = DC_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       Write_Data,
    output logic [31:0]       Read_data,
    output logic              Stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

    logic [1:0]        state_q,      state_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic [31:0]       hit_count_q,  hit_count_d;
    logic [31:0]       miss_count_q, miss_count_d;

    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [31:0]       lookup_data;
    logic              arr_we;
    logic [31:0]       arr_wdata;
    logic              unused_addr_bits;

    // The live pipeline address is looked up in IDLE; the latched copy is used while a request is in flight.
    assign lookup_addr      = (state_q == ST_IDLE) ? Address : mem_addr_q;
    assign unused_addr_bits = ^lookup_addr[1:0];

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (CLK),
        .clr      (RESET),
        .rd_index (lookup_addr[INDEX_BITS+1:2]),
        .rd_tag   (lookup_addr[ADDR_W-1:INDEX_BITS+2]),
        .rd_hit   (lookup_hit),
        .rd_data  (lookup_data),
        .wr_en    (arr_we),
        .wr_index (mem_addr_q[INDEX_BITS+1:2]),
        .wr_tag   (mem_addr_q[ADDR_W-1:INDEX_BITS+2]),
        .wr_data  (arr_wdata)
    );

    // Next-state, handshake register and counter logic; writes take priority over reads.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        arr_we       = 1'b0;
        arr_wdata    = mem_rdata;
        case (state_q)
            ST_IDLE: begin
                if (MemWrite) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {Address[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = Write_Data;
                    state_d     = ST_WRITE;
                end else if (MemRead) begin
                    if (lookup_hit) begin
                        hit_count_d = hit_count_q + 32'd1;
                    end else begin
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = {Address[ADDR_W-1:2], 2'b00};
                        miss_count_d = miss_count_q + 32'd1;
                        state_d      = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    arr_we    = 1'b1;
                    arr_wdata = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    arr_we    = lookup_hit;
                    arr_wdata = mem_wdata_q;
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (RESET) begin
            arr_we = 1'b0;
        end
    end

    // Pipeline-facing outputs: zero-latency hits in IDLE, one release cycle in DONE.
    always_comb begin
        Stall     = 1'b0;
        Read_data = '0;
        case (state_q)
            ST_IDLE: begin
                Stall = MemWrite | (MemRead & ~lookup_hit);
                if (MemRead && !MemWrite && lookup_hit) begin
                    Read_data = lookup_data;
                end
            end
            ST_FILL, ST_WRITE: begin
                Stall = 1'b1;
            end
            default: begin
                if (MemRead && !MemWrite) begin
                    Read_data = lookup_data;
                end
            end
        endcase
    end

    // State registers; reset abandons any outstanding request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
Direct-mapped, write-through, no-write-allocate data cache that services MEM-stage load/store requests from the pipeline. Toward the pipeline it is the responder: it returns read data and holds Stall high while a request is outstanding. Toward the backing memory it is the initiator, using a req/ack handshake. It sits between the EX/MEM register outputs and the backing data memory, in place of the zero-latency data memory.

Parameters:
INDEX_BITS, 4, log2 of line count (16 lines, one 32-bit word per line)
ADDR_W, 32, byte address width; tag = ADDR_W-INDEX_BITS-2 bits

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
MemRead  in  1  load request from MEM stage
MemWrite  in  1  store request from MEM stage
Address  in  32  byte address; bits [1:0] ignored
Write_Data  in  32  store data
Read_data  out  32  load data; valid when MemRead=1 and Stall=0
Stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM while 1
mem_req  out  1  backing-memory request, registered
mem_we  out  1  1 = write, 0 = read; registered
mem_addr  out  32  word-aligned address {Address[31:2],2'b00}; registered
mem_wdata  out  32  write data; registered
mem_rdata  in  32  read data; valid in the cycle mem_ack=1
mem_ack  in  1  one-cycle completion pulse
hit_count  out  32  completed read hits, wrapping
miss_count  out  32  read misses, wrapping

Behaviour:
- Line array: valid[2^INDEX_BITS], tag, data. index = Address[INDEX_BITS+1:2]; hit = valid[index] & tag match.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE, no request: Stall=0, Read_data=0.
- IDLE, MemRead & hit: Read_data = line data combinationally; Stall=0; hit_count+1; stay IDLE. Zero added latency.
- IDLE, MemRead & miss: Stall=1 in the same cycle. Next edge: mem_req=1, mem_we=0, mem_addr latched, miss_count+1, go to FILL.
- IDLE, MemWrite (hit or miss): Stall=1. Next edge: mem_req=1, mem_we=1, addr/wdata latched, go to WRITE.
- MemRead & MemWrite both high: treated as a write.
- FILL: Stall=1. On mem_ack, write valid/tag/data=mem_rdata to the line, drop mem_req, go to DONE.
- WRITE: Stall=1. On mem_ack, if the line hits, update its data with the latched wdata (a miss leaves the array unchanged); drop mem_req, go to DONE.
- DONE: Stall=0 for exactly one cycle so the pipeline retires the op without re-issuing it.
  - A read returns line data; hit_count does not increment.
  - Always return to IDLE.
- Miss penalty: ack latency + 2 cycles (issue cycle + DONE).
- Handshake rules:
  - mem_req, mem_we, mem_addr, mem_wdata stay stable from assertion until the cycle after mem_ack.
  - Only one request is ever outstanding.
  - mem_ack outside FILL/WRITE is ignored.
- Stall = (IDLE & ((MemRead & ~hit) | MemWrite)) | FILL | WRITE.
- Counters wrap from 0xFFFFFFFF to 0.
- Reset, including mid-FILL/WRITE: next state IDLE; all valid bits cleared; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; counters=0. Any late mem_ack is ignored.
- Reset values of outputs: Read_data=0, Stall=0, hit_count=0, miss_count=0.
- Line data and tag arrays are not reset; only the valid bits are.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'd0, FILL=2'd1, WRITE=2'd2, DONE=2'd3
  - line-count and tag-width constants derived from INDEX_BITS
- One sub-module, dcache_array: valid/tag/data storage with a combinational read port, a single write port and synchronous valid clear.
- FSM, handshake registers and counters stay in dcache_responder.

Test Plan:
- Reset, then MemRead Address=0x40 with mem_ack returned 3 cycles after mem_req and mem_rdata=0xDEADBEEF -> Stall=1 for 5 cycles, DONE cycle Read_data=0xDEADBEEF, miss_count=1; repeat read -> Stall=0 same cycle, hit_count=1.
- MemWrite 0x40 data 0x12345678 after the fill above -> mem_req=1, mem_we=1, mem_addr=0x40, mem_wdata=0x12345678 held until ack; then MemRead 0x40 -> hit returning 0x12345678.
- MemWrite to miss address 0x80 -> write-through issued; following MemRead 0x80 misses (no allocate); miss_count increments.
- Conflict: fill 0x40, then fill 0x80 (same index, INDEX_BITS=4) -> read 0x40 misses again.
- RESET asserted in the second FILL cycle -> next cycle mem_req=0, Stall=0, state IDLE; a late mem_ack is ignored; read 0x40 misses.
- Spurious mem_ack in IDLE, and MemRead & MemWrite both high -> no state change from the ack; the dual request is handled as a write (mem_we=1).
